// File: rtl/vid_phy_controller_v2_2_dru_align_pkg.sv
// Shared types and helpers for the multi-channel DRU output aligner.
package vid_phy_controller_v2_2_dru_align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } align_state_t;

    localparam int unsigned RESYNC_CNT_W = 16;

    // Count needs one bit more than the pointer so that "full" is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $unsigned($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/vid_phy_controller_v2_2_dru_lane_fifo.sv
// Single-lane register FIFO: push/pop with flush, occupancy count, full and
// drop (overflow) indication. Pointers wrap modulo DEPTH (power of two).
module vid_phy_controller_v2_2_dru_lane_fifo
    import vid_phy_controller_v2_2_dru_align_pkg::*;
#(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Qualify push/pop; a full lane still accepts a push when it pops in the same cycle.
    always_comb begin
        full  = (count == CW'(DEPTH));
        rd_en = pop && !flush && (count != '0);
        wr_en = push && !flush && (!full || rd_en);
        ovf   = push && !flush && full && !rd_en;
        dout  = mem[rd_ptr];
    end

    // Storage array; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; flush empties the lane in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vid_phy_controller_v2_2_dru_mc_align.sv
// Multi-channel DRU output aligner: per-lane elastic FIFOs with prefill,
// lockstep release of one word per active lane, coordinated flush on
// overflow or lane-mask change.
// Optional status outputs (FILL_OUT, RESYNC_CNT_OUT) are built when
// VID_PHY_DRU_ALIGN_STATUS_EN is defined.
module vid_phy_controller_v2_2_dru_mc_align
    import vid_phy_controller_v2_2_dru_align_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned WIDTH   = 40,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PREFILL = 4
) (
    input  logic                      DRU_CLK_IN,
    input  logic                      DRU_RST_N_IN,
    input  logic [NUM_CH-1:0]         CH_EN_IN,
    input  logic [NUM_CH*WIDTH-1:0]   DAT_IN,
    input  logic [NUM_CH-1:0]         DAT_EN_IN,
    output logic [NUM_CH*WIDTH-1:0]   DAT_OUT,
    output logic                      DAT_VLD_OUT,
    output logic                      LOCK_OUT,
    output logic [NUM_CH-1:0]         OVF_OUT,
    input  logic                      OVF_CLR_IN
`ifdef VID_PHY_DRU_ALIGN_STATUS_EN
    ,
    output logic [NUM_CH*cnt_w(DEPTH)-1:0] FILL_OUT,
    output logic [RESYNC_CNT_W-1:0]        RESYNC_CNT_OUT
`endif
);

    localparam int unsigned CW = cnt_w(DEPTH);

    align_state_t         state_q;
    align_state_t         state_d;
    logic [NUM_CH-1:0]    ch_en_q;

    logic [CW-1:0]        fifo_cnt  [NUM_CH];
    logic [WIDTH-1:0]     fifo_dout [NUM_CH];
    logic [NUM_CH-1:0]    fifo_full;
    logic [NUM_CH-1:0]    fifo_ovf;

    logic [NUM_CH-1:0]    lane_push;
    logic [NUM_CH-1:0]    lane_pop;
    logic [NUM_CH-1:0]    lane_flush;
    logic [NUM_CH-1:0]    lane_ready;
    logic [NUM_CH-1:0]    lane_prefilled;
    logic                 accepting;
    logic                 pop_all;
    logic                 any_ovf;
    logic                 mask_chg;
    logic [NUM_CH*WIDTH-1:0] dat_nxt;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            vid_phy_controller_v2_2_dru_lane_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (DRU_CLK_IN),
                .rst_n (DRU_RST_N_IN),
                .push  (lane_push[g]),
                .pop   (lane_pop[g]),
                .flush (lane_flush[g]),
                .din   (DAT_IN[g*WIDTH +: WIDTH]),
                .dout  (fifo_dout[g]),
                .count (fifo_cnt[g]),
                .full  (fifo_full[g]),
                .ovf   (fifo_ovf[g])
            );
        end
    endgenerate

    // Per-lane push/pop/flush control; inactive lanes are held empty and
    // treated as always ready so they never block release.
    always_comb begin
        accepting      = (state_q == ST_FILL) || (state_q == ST_RUN);
        lane_push      = '0;
        lane_flush     = '0;
        lane_ready     = '0;
        lane_prefilled = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            lane_push[n]      = accepting && ch_en_q[n] && DAT_EN_IN[n];
            lane_flush[n]     = !accepting || !ch_en_q[n];
            lane_ready[n]     = !ch_en_q[n] || (fifo_cnt[n] != '0);
            lane_prefilled[n] = !ch_en_q[n] || (fifo_cnt[n] >= CW'(PREFILL));
        end
        pop_all  = (state_q == ST_RUN) && (&lane_ready) && (|ch_en_q);
        lane_pop = pop_all ? ch_en_q : '0;
        any_ovf  = |(lane_push & fifo_full & ~lane_pop);
        mask_chg = (CH_EN_IN != ch_en_q);
        dat_nxt  = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (lane_pop[n]) begin
                dat_nxt[n*WIDTH +: WIDTH] = fifo_dout[n];
            end
        end
    end

    // Next-state logic for the fill/run/flush sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|CH_EN_IN) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mask_chg || any_ovf) begin
                    state_d = ST_FLUSH;
                end else if (&lane_prefilled) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mask_chg || any_ovf) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = (|CH_EN_IN) ? ST_FILL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, sampled lane mask, registered outputs and sticky overflow flags.
    always_ff @(posedge DRU_CLK_IN or negedge DRU_RST_N_IN) begin
        if (!DRU_RST_N_IN) begin
            state_q     <= ST_IDLE;
            ch_en_q     <= '0;
            DAT_OUT     <= '0;
            DAT_VLD_OUT <= 1'b0;
            LOCK_OUT    <= 1'b0;
            OVF_OUT     <= '0;
        end else begin
            state_q     <= state_d;
            ch_en_q     <= CH_EN_IN;
            DAT_OUT     <= dat_nxt;
            DAT_VLD_OUT <= pop_all;
            LOCK_OUT    <= (state_q == ST_RUN);
            OVF_OUT     <= (OVF_CLR_IN ? '0 : OVF_OUT) | fifo_ovf;
        end
    end

`ifdef VID_PHY_DRU_ALIGN_STATUS_EN
    // Status: registered lane occupancy and saturating overflow-resync counter.
    always_ff @(posedge DRU_CLK_IN or negedge DRU_RST_N_IN) begin
        if (!DRU_RST_N_IN) begin
            FILL_OUT       <= '0;
            RESYNC_CNT_OUT <= '0;
        end else begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                FILL_OUT[n*CW +: CW] <= fifo_cnt[n];
            end
            if (OVF_CLR_IN) begin
                RESYNC_CNT_OUT <= any_ovf ? RESYNC_CNT_W'(1) : '0;
            end else if (any_ovf && (RESYNC_CNT_OUT != '1)) begin
                RESYNC_CNT_OUT <= RESYNC_CNT_OUT + RESYNC_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vid_phy_controller_v2_2_dru_mc_align.sv
// Self-checking bench for vid_phy_controller_v2_2_dru_mc_align (NUM_CH=3,
// WIDTH=40, DEPTH=8, PREFILL=4). Optional status ports are connected when
// VID_PHY_DRU_ALIGN_STATUS_EN is defined.
module tb_vid_phy_controller_v2_2_dru_mc_align;

    localparam int unsigned NCH = 3;
    localparam int unsigned W   = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   ch_en = '0;
    logic [NCH*W-1:0] dat_in = '0;
    logic [NCH-1:0]   dat_en = '0;
    logic [NCH*W-1:0] dat_out;
    logic             dat_vld;
    logic             lock;
    logic [NCH-1:0]   ovf;
    logic             ovf_clr = 1'b0;
`ifdef VID_PHY_DRU_ALIGN_STATUS_EN
    logic [NCH*4-1:0] fill_cnt;
    logic [15:0]      resync_cnt;
`endif

    vid_phy_controller_v2_2_dru_mc_align #(
        .NUM_CH  (3),
        .WIDTH   (40),
        .DEPTH   (8),
        .PREFILL (4)
    ) dut (
        .DRU_CLK_IN     (clk),
        .DRU_RST_N_IN   (rst_n),
        .CH_EN_IN       (ch_en),
        .DAT_IN         (dat_in),
        .DAT_EN_IN      (dat_en),
        .DAT_OUT        (dat_out),
        .DAT_VLD_OUT    (dat_vld),
        .LOCK_OUT       (lock),
        .OVF_OUT        (ovf),
        .OVF_CLR_IN     (ovf_clr)
`ifdef VID_PHY_DRU_ALIGN_STATUS_EN
        ,
        .FILL_OUT       (fill_cnt),
        .RESYNC_CNT_OUT (resync_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch_en;
        logic [2:0] den;
        int         w;
        logic       vld;
        logic       lock;
        logic [2:0] ovf;
        int         ew;
    } vec_t;

    vec_t tbl [20];
    int   nvec = 0;
    int   nerr = 0;
    int   k [NCH];

    function automatic logic [W-1:0] mkdat(input int lane, input int w);
        return {8'(lane), 32'(w)};
    endfunction

    function automatic logic [NCH*W-1:0] bus(input int w);
        logic [NCH*W-1:0] r;
        r = '0;
        if (w >= 0) begin
            for (int n = 0; n < NCH; n++) r[n*W +: W] = mkdat(n, w);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [NCH*W-1:0] act, input logic [NCH*W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_step(input logic [2:0] den);
        dat_en = den;
        for (int n = 0; n < NCH; n++) dat_in[n*W +: W] = mkdat(n, k[n]);
        step();
        for (int n = 0; n < NCH; n++) if (den[n]) k[n]++;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ch_en   = '0;
        dat_en  = '0;
        dat_in  = '0;
        ovf_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int n = 0; n < NCH; n++) k[n] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int expk;
        logic seen;

        tbl[0]  = '{3'b111, 3'b000,  0, 1'b0, 1'b0, 3'b000, -1};
        tbl[1]  = '{3'b111, 3'b111,  0, 1'b0, 1'b0, 3'b000, -1};
        tbl[2]  = '{3'b111, 3'b111,  1, 1'b0, 1'b0, 3'b000, -1};
        tbl[3]  = '{3'b111, 3'b111,  2, 1'b0, 1'b0, 3'b000, -1};
        tbl[4]  = '{3'b111, 3'b111,  3, 1'b0, 1'b0, 3'b000, -1};
        tbl[5]  = '{3'b111, 3'b111,  4, 1'b0, 1'b0, 3'b000, -1};
        tbl[6]  = '{3'b111, 3'b111,  5, 1'b1, 1'b1, 3'b000,  0};
        tbl[7]  = '{3'b111, 3'b111,  6, 1'b1, 1'b1, 3'b000,  1};
        tbl[8]  = '{3'b111, 3'b111,  7, 1'b1, 1'b1, 3'b000,  2};
        tbl[9]  = '{3'b111, 3'b111,  8, 1'b1, 1'b1, 3'b000,  3};
        tbl[10] = '{3'b111, 3'b111,  9, 1'b1, 1'b1, 3'b000,  4};
        tbl[11] = '{3'b111, 3'b111, 10, 1'b1, 1'b1, 3'b000,  5};
        tbl[12] = '{3'b111, 3'b000,  0, 1'b1, 1'b1, 3'b000,  6};
        tbl[13] = '{3'b111, 3'b000,  0, 1'b1, 1'b1, 3'b000,  7};
        tbl[14] = '{3'b111, 3'b000,  0, 1'b1, 1'b1, 3'b000,  8};
        tbl[15] = '{3'b111, 3'b000,  0, 1'b1, 1'b1, 3'b000,  9};
        tbl[16] = '{3'b111, 3'b000,  0, 1'b1, 1'b1, 3'b000, 10};
        tbl[17] = '{3'b111, 3'b000,  0, 1'b0, 1'b1, 3'b000, -1};
        tbl[18] = '{3'b111, 3'b111, 11, 1'b0, 1'b1, 3'b000, -1};
        tbl[19] = '{3'b111, 3'b111, 12, 1'b1, 1'b1, 3'b000, 11};

        // Reset values
        do_reset();
        chk("rst_dat",  dat_out, '0);
        chk("rst_vld",  {119'd0, dat_vld}, '0);
        chk("rst_lock", {119'd0, lock}, '0);
        chk("rst_ovf",  {117'd0, ovf}, '0);

        // Fill, lock, steady run, drain to empty and restart
        for (int i = 0; i < 20; i++) begin
            ch_en = tbl[i].ch_en;
            for (int n = 0; n < NCH; n++) k[n] = tbl[i].w;
            push_step(tbl[i].den);
            chk($sformatf("tbl%0d_vld", i),  {119'd0, dat_vld}, {119'd0, tbl[i].vld});
            chk($sformatf("tbl%0d_lock", i), {119'd0, lock},    {119'd0, tbl[i].lock});
            chk($sformatf("tbl%0d_ovf", i),  {117'd0, ovf},     {117'd0, tbl[i].ovf});
            chk($sformatf("tbl%0d_dat", i),  dat_out, bus(tbl[i].ew));
        end

        // Lane 0 leads lanes 1/2 by two words: output aligned by FIFO index
        do_reset();
        ch_en = 3'b111;
        push_step(3'b000);
        expk = 0;
        for (int s = 0; s < 40 && expk < 10; s++) begin
            push_step((s >= 2) ? 3'b111 : 3'b001);
            if (dat_vld) begin
                chk($sformatf("skew_dat%0d", expk), dat_out, bus(expk));
                expk++;
            end
        end
        chk("skew_words", 120'(expk), 120'(10));
        chk("skew_ovf", {117'd0, ovf}, '0);

        // Lane 1 at half rate: lanes 0/2 overflow, flush and refill
        do_reset();
        ch_en = 3'b111;
        push_step(3'b000);
        seen = 1'b0;
        for (int s = 0; s < 60 && !seen; s++) begin
            push_step({1'b1, ((s % 2) == 0), 1'b1});
            if (ovf != '0) seen = 1'b1;
        end
        chk("ovf_lanes", {117'd0, ovf}, {117'd0, 3'b101});
        push_step(3'b000);
        chk("ovf_lock_lo1", {119'd0, lock}, '0);
        push_step(3'b000);
        chk("ovf_lock_lo2", {119'd0, lock}, '0);
        chk("ovf_sticky", {117'd0, ovf}, {117'd0, 3'b101});
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", {117'd0, ovf}, '0);

        // Full lane with simultaneous push and pop is not an overflow
        do_reset();
        ch_en = 3'b111;
        push_step(3'b000);
        for (int s = 0; s < 8; s++) push_step(3'b001);
        for (int s = 0; s < 5; s++) push_step(3'b110);
        chk("full_prerun_ovf", {117'd0, ovf}, '0);
        for (int s = 0; s < 3; s++) begin
            push_step(3'b111);
            chk($sformatf("full_pp%0d_ovf", s),  {117'd0, ovf}, '0);
            chk($sformatf("full_pp%0d_vld", s),  {119'd0, dat_vld}, {119'd0, 1'b1});
            chk($sformatf("full_pp%0d_lock", s), {119'd0, lock}, {119'd0, 1'b1});
        end

        // Clear pulse coincident with an overflow: the set wins
        do_reset();
        ch_en = 3'b011;
        push_step(3'b000);
        for (int s = 0; s < 8; s++) push_step(3'b001);
        chk("clr_race_pre", {117'd0, ovf}, '0);
        ovf_clr = 1'b1;
        push_step(3'b001);
        ovf_clr = 1'b0;
        chk("clr_race_set", {117'd0, ovf}, {117'd0, 3'b001});

        // Mask change 111 -> 011 during RUN
        do_reset();
        ch_en = 3'b111;
        push_step(3'b000);
        for (int s = 0; s < 20 && !lock; s++) push_step(3'b111);
        chk("mask_locked", {119'd0, lock}, {119'd0, 1'b1});
        ch_en = 3'b011;
        push_step(3'b111);
        chk("mask_chg_lock", {119'd0, lock}, {119'd0, 1'b1});
        push_step(3'b111);
        chk("mask_flush_lock", {119'd0, lock}, '0);
        chk("mask_flush_vld", {119'd0, dat_vld}, '0);
        chk("mask_flush_l2", {80'd0, dat_out[119:80]}, '0);
        for (int s = 0; s < 20 && !dat_vld; s++) push_step(3'b111);
        chk("mask_relock_vld", {119'd0, dat_vld}, {119'd0, 1'b1});
        for (int s = 0; s < 4; s++) begin
            push_step(3'b111);
            chk($sformatf("mask_run%0d_l2", s), {80'd0, dat_out[119:80]}, '0);
            chk($sformatf("mask_run%0d_idx", s), {88'd0, dat_out[31:0]}, {88'd0, dat_out[71:40]});
            chk($sformatf("mask_run%0d_vld", s), {119'd0, dat_vld}, {119'd0, 1'b1});
        end

        // Asynchronous reset mid-RUN, then clean restart
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_dat",  dat_out, '0);
        chk("arst_vld",  {119'd0, dat_vld}, '0);
        chk("arst_lock", {119'd0, lock}, '0);
        chk("arst_ovf",  {117'd0, ovf}, '0);
        dat_en = '0;
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            push_step(3'b000);
            chk($sformatf("arst_idle%0d_vld", s), {119'd0, dat_vld}, '0);
            chk($sformatf("arst_idle%0d_dat", s), dat_out, '0);
        end
        for (int n = 0; n < NCH; n++) k[n] = 100;
        for (int s = 0; s < 20 && !dat_vld; s++) push_step(3'b011);
        chk("arst_first_vld", {119'd0, dat_vld}, {119'd0, 1'b1});
        chk("arst_first_dat", dat_out, {40'd0, mkdat(1, 100), mkdat(0, 100)});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vid_phy_controller_v2_2_dru_mc_align.md
# vid_phy_controller_v2_2_dru_mc_align

Multi-channel DRU output aligner: accepts the bursty, enable-qualified recovered words from NUM_CH DRU instances (one per TMDS/link lane) and releases them as lane-aligned words, one word per lane in the same cycle. Each lane gets a small elastic FIFO with prefill. Overflow triggers a coordinated flush/resync. Sits between the per-lane DRU wrappers and the link-layer word aligner.

## Interface
- NUM_CH, 3, number of lanes (1..4)
- WIDTH, 40, word width per lane (20 or 40)
- DEPTH, 8, per-lane FIFO depth in words (power of two, 4..32)
- PREFILL, 4, words required in every active lane before release (1..DEPTH-1)

- DRU_CLK_IN  in  1  link clock, all logic on rising edge
- DRU_RST_N_IN  in  1  reset; asynchronous, active-low
- CH_EN_IN  in  NUM_CH  active-lane mask
- DAT_IN  in  NUM_CH*WIDTH  lane words, lane n at [n*WIDTH +: WIDTH]
- DAT_EN_IN  in  NUM_CH  per-lane word valid (DRU data enable)
- DAT_OUT  out  NUM_CH*WIDTH  aligned lane words; inactive lanes drive 0
- DAT_VLD_OUT  out  1  DAT_OUT valid for all active lanes
- LOCK_OUT  out  1  high in RUN state
- OVF_OUT  out  NUM_CH  sticky per-lane overflow
- OVF_CLR_IN  in  1  clears OVF_OUT (single-cycle pulse)

## Operation
- States: IDLE, FILL, FLUSH, RUN. Reset state IDLE.
- IDLE: CH_EN_IN == 0. All FIFOs empty, DAT_EN_IN ignored. Leaves for FILL when the mask becomes nonzero.
- FILL: active lanes push on DAT_EN_IN; no pops. Goes to RUN when every active lane count >= PREFILL.
- RUN: pop all active lanes in cycle t iff every active lane count > 0. No partial pops.
- FLUSH: lasts one cycle. All pointers and counts are zeroed; any push in that cycle is discarded. Next state is FILL, or IDLE if the mask is 0.
- CH_EN_IN changes in any state other than IDLE: next state is FLUSH. The mask is sampled into a register; the registered copy governs lane activity.
- Inactive lanes: pushes are ignored, the FIFO is held empty, the lane is excluded from the all-nonempty and prefill checks.
- Overflow: push to a full lane with no simultaneous pop. The word is dropped, OVF_OUT[n] is set, next state is FLUSH. A full lane with push and pop in the same cycle is not an overflow.
- Push and pop on the same lane in the same cycle: count unchanged, data ordering preserved.
- Count width is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- OVF_CLR_IN and a new overflow in the same cycle: the set wins.

## Timing
- Reset values: DAT_OUT 0, DAT_VLD_OUT 0, LOCK_OUT 0, OVF_OUT 0, all counts 0.
- A push at edge t is counted from t+1. The minimum latency from push to DAT_OUT is 2 cycles when PREFILL=1.
- Pop decision in cycle t → DAT_OUT/DAT_VLD_OUT registered at t+1.
- DAT_VLD_OUT is 0 in any cycle following a non-RUN state. LOCK_OUT = registered (state == RUN).
- An asynchronous reset mid-operation clears everything immediately. Deassertion is synchronised externally.

## Configuration
- VID_PHY_DRU_ALIGN_STATUS_EN defined: adds two outputs.
  - FILL_OUT (NUM_CH*($clog2(DEPTH)+1)): registered per-lane counts.
  - RESYNC_CNT_OUT (16): counts FLUSH entries caused by overflow, saturates at 16'hFFFF, cleared by OVF_CLR_IN.
- Not defined: neither port exists; no counter logic.

## Structure
- Package vid_phy_controller_v2_2_dru_align_pkg:
  - state enum (IDLE, FILL, FLUSH, RUN)
  - count-width function
  - RESYNC_CNT_W = 16
- Sub-module vid_phy_controller_v2_2_dru_lane_fifo: single-lane register FIFO with push, pop, flush, count, full and overflow outputs. It is instantiated NUM_CH times in a generate loop.

## Test plan
- NUM_CH=3, all lanes enabled, DAT_EN_IN=1 every cycle, incrementing data → LOCK_OUT rises after PREFILL fill. DAT_VLD_OUT is continuous thereafter and all lanes carry the same sequence index.
- Lane 1 enable at 50% duty, lanes 0/2 at 100% → lanes 0/2 reach DEPTH=8 with no pop, OVF_OUT=3'b101. The bench sees FLUSH and then FILL again, with LOCK_OUT dropping for at least 2 cycles.
- Lanes skewed by 2 words, all lanes at 100% → output words are aligned by FIFO index and no data is lost.
- CH_EN_IN 3'b111 → 3'b011 during RUN → FLUSH within 1 cycle. Lane 2 output is 0, and lanes 0/1 refill and relock.
- Full lane with simultaneous push and pop → no OVF_OUT. OVF_CLR_IN pulsed in the same cycle as an overflow → OVF_OUT stays set.
- DRU_RST_N_IN asserted mid-RUN → all outputs 0 asynchronously. After release, state is IDLE/FILL and no stale words appear on DAT_OUT.
